// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for serial_adder.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    // Requester side: issues operands, observes status and result.
    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    // Adder side.
    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder that ripples DIGIT bits per clock through a
// registered carry. WIDTH/DIGIT clocks per operation, one-cycle done pulse,
// result (sum, cout, signed overflow) held until the next completion.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub input, which turns
// the operation into a - b computed as a + ~b + 1.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
        $error("serial_adder: DIGIT must lie in 1..WIDTH and divide WIDTH evenly");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             accept;
    logic             step;
    logic             last;
    logic             busy_c;
    logic             done_c;

    logic [CNT_W-1:0] cnt;

    // acc starts as operand A and fills with sum digits from the top as A's
    // digits are consumed from the bottom, so one register serves both roles.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] b_nxt;
    logic             carry;

    logic [WIDTH-1:0] b_load;
    logic             cin_load;

    logic [DIGIT:0]   c;
    logic [DIGIT-1:0] dsum;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    assign last = (cnt == LAST);

    // Operand conditioning at capture: subtraction inverts B and forces carry-in.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        b_load   = bus.sub ? ~bus.b : bus.b;
        cin_load = bus.sub ? 1'b1 : bus.cin;
`else
        b_load   = bus.b;
        cin_load = bus.cin;
`endif
    end

    // DIGIT chained full-adder slices on the current low digit of A and B.
    always_comb begin
        c    = '0;
        dsum = '0;
        c[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            dsum[i]  = acc[i] ^ b_sh[i] ^ c[i];
            c[i + 1] = (acc[i] & b_sh[i]) | (c[i] & (acc[i] ^ b_sh[i]));
        end
    end

    if (DIGIT < WIDTH) begin : g_multi_digit
        assign acc_nxt = {dsum, acc[WIDTH-1:DIGIT]};
        assign b_nxt   = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
    end else begin : g_single_digit
        assign acc_nxt = dsum;
        assign b_nxt   = '0;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; start is honoured only in IDLE or DONE.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy_c = 1'b1;
                step   = 1'b1;
                if (last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Digit counter: cleared on capture, advances once per processed digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    // Working operands and carry; only meaningful while RUN, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            acc   <= bus.a;
            b_sh  <= b_load;
            carry <= cin_load;
        end else if (step) begin
            acc   <= acc_nxt;
            b_sh  <= b_nxt;
            carry <= c[DIGIT];
        end
    end

    // Result registers update only on the final digit; an aborted run leaves
    // them at their reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (step && last) begin
            sum_q  <= acc_nxt;
            cout_q <= c[DIGIT];
            ovf_q  <= c[DIGIT] ^ c[DIGIT-1];
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.sum      = sum_q;
    assign bus.cout     = cout_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized and directed bench for serial_adder with three
// geometries: 8/1, 16/4 and 8/8 (WIDTH/DIGIT).
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(8))  bus8 ();
    serial_adder_if #(.WIDTH(16)) bus16 ();
    serial_adder_if #(.WIDTH(8))  bus8w ();

    serial_adder #(.WIDTH(8),  .DIGIT(1)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    serial_adder #(.WIDTH(8),  .DIGIT(8)) dut8w (.clk(clk), .rst(rst), .bus(bus8w));

`ifdef SERIAL_ADDER_SUB_EN
    logic sub8 = 1'b0;
`endif

    // Reference: {overflow, cout, sum} of a + b + cin in w-bit arithmetic.
    function automatic logic [33:0] add_model(input int w, input logic [31:0] a,
                                              input logic [31:0] b, input logic cin);
        logic [63:0] full;
        logic [63:0] mask;
        logic [31:0] s;
        logic        co;
        logic        ov;
        full = 64'(a) + 64'(b) + 64'(cin);
        mask = (64'd1 << w) - 64'd1;
        s    = 32'(full & mask);
        co   = full[w];
        ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    // Reference: {overflow, no-borrow, difference} of a - b in w-bit arithmetic.
    function automatic logic [33:0] sub_model(input int w, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] mask;
        logic [31:0] s;
        logic        co;
        logic        ov;
        mask = (64'd1 << w) - 64'd1;
        s    = 32'((64'(a) - 64'(b)) & mask);
        co   = (a >= b);
        ov   = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
        return {ov, co, s};
    endfunction

    // One operation on the 8/1 instance; entered #1 after an edge with the DUT
    // in IDLE or DONE, returns #1 after the edge that raised done (or timeout).
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [9:0] res, output int lat, output int busy_cycles);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.cin   = cin;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub   = sub8;
`endif
        @(posedge clk);
        #1;
        bus8.start  = 1'b0;
        bus8.a      = 8'($urandom);
        bus8.b      = 8'($urandom);
        bus8.cin    = 1'($urandom);
        lat         = 0;
        busy_cycles = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            if (bus8.busy === 1'b1) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = {bus8.overflow, bus8.cout, bus8.sum};
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus8.busy, bus8.done, bus8.overflow, bus8.cout, bus8.sum} !== 12'h000) begin
            bad++;
            $display("FAIL reset8: got %h want 000", {bus8.busy, bus8.done, bus8.overflow, bus8.cout, bus8.sum});
        end
        total++;
        if ({bus16.busy, bus16.done, bus16.overflow, bus16.cout, bus16.sum} !== 20'h00000) begin
            bad++;
            $display("FAIL reset16: got %h want 00000", {bus16.busy, bus16.done, bus16.overflow, bus16.cout, bus16.sum});
        end
        total++;
        if ({bus8w.busy, bus8w.done, bus8w.overflow, bus8w.cout, bus8w.sum} !== 12'h000) begin
            bad++;
            $display("FAIL reset8w: got %h want 000", {bus8w.busy, bus8w.done, bus8w.overflow, bus8w.cout, bus8w.sum});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [7:0] va[4]   = '{8'h00, 8'hFF, 8'h7F, 8'h80};
        logic [7:0] vb[4]   = '{8'h00, 8'h01, 8'h01, 8'h80};
        logic       vc[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [9:0] vexp[4] = '{10'h000, 10'h100, 10'h280, 10'h301};
        logic [9:0] res;
        int         lat;
        int         bc;
        for (int i = 0; i < 4; i++) begin
            run8(va[i], vb[i], vc[i], res, lat, bc);
            total++;
            if (res !== vexp[i]) begin
                bad++;
                $display("FAIL directed_result[%0d]: got %h want %h", i, res, vexp[i]);
            end
            total++;
            if (lat != 8 || bc != 8 || bus8.busy !== 1'b0) begin
                bad++;
                $display("FAIL directed_timing[%0d]: got lat=%0d busy_cycles=%0d busy_at_done=%b want 8/8/0", i, lat, bc, bus8.busy);
            end
            @(posedge clk);
            #1;
            total++;
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) begin
                bad++;
                $display("FAIL directed_pulse[%0d]: got done=%b busy=%b want 0/0", i, bus8.done, bus8.busy);
            end
        end
    endtask

    task automatic test_random;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ci;
        logic [33:0] e;
        logic [9:0]  res;
        int          lat;
        int          bc;
        for (int i = 0; i < 16; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            ci = 1'($urandom);
            e  = add_model(8, 32'(a), 32'(b), ci);
            run8(a, b, ci, res, lat, bc);
            total++;
            if (res !== {e[33:32], e[7:0]} || lat != 8) begin
                bad++;
                $display("FAIL random[%0d] %h+%h+%b: got %h lat=%0d want %h lat=8", i, a, b, ci, res, lat, {e[33:32], e[7:0]});
            end
            if (i % 2 == 1) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    // start held high with fresh operands every cycle: only the values present
    // at accepting edges (0, 9, 18) may reach the result.
    task automatic test_back_to_back;
        logic [7:0]  qa[27];
        logic [7:0]  qb[27];
        logic        qc[27];
        logic [33:0] e;
        int          dones = 0;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub = 1'b0;
`endif
        for (int k = 0; k < 27; k++) begin
            qa[k] = 8'($urandom);
            qb[k] = 8'($urandom);
            qc[k] = 1'($urandom);
            bus8.start = 1'b1;
            bus8.a     = qa[k];
            bus8.b     = qb[k];
            bus8.cin   = qc[k];
            @(posedge clk);
            #1;
            if (bus8.done === 1'b1) begin
                total++;
                if (k != 8 + 9 * dones || bus8.busy !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_timing: got done at edge %0d busy=%b want edge %0d busy=0", k, bus8.busy, 8 + 9 * dones);
                end else begin
                    e = add_model(8, 32'(qa[k-8]), 32'(qb[k-8]), qc[k-8]);
                    total++;
                    if ({bus8.overflow, bus8.cout, bus8.sum} !== {e[33:32], e[7:0]}) begin
                        bad++;
                        $display("FAIL b2b_result: got %h want %h", {bus8.overflow, bus8.cout, bus8.sum}, {e[33:32], e[7:0]});
                    end
                end
                dones++;
            end
        end
        bus8.start = 1'b0;
        total++;
        if (dones != 3) begin
            bad++;
            $display("FAIL b2b_count: got %0d done pulses want 3", dones);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_abort;
        logic [9:0] res;
        int         lat;
        int         bc;
        int         stray = 0;
        run8(8'h7F, 8'h01, 1'b0, res, lat, bc);
        total++;
        if (res !== 10'h280) begin
            bad++;
            $display("FAIL abort_pre: got %h want 280", res);
        end
        bus8.start = 1'b1;
        bus8.a     = 8'h3C;
        bus8.b     = 8'h42;
        bus8.cin   = 1'b0;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if ({bus8.busy, bus8.done, bus8.overflow, bus8.cout, bus8.sum} !== 12'h000) begin
            bad++;
            $display("FAIL abort_reset: got %h want 000", {bus8.busy, bus8.done, bus8.overflow, bus8.cout, bus8.sum});
        end
        for (int k = 0; k < 12; k++) begin
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) stray++;
            @(posedge clk);
            #1;
        end
        total++;
        if (stray != 0) begin
            bad++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", stray);
        end
        run8(8'h3C, 8'h42, 1'b0, res, lat, bc);
        total++;
        if (res !== 10'h07E || lat != 8) begin
            bad++;
            $display("FAIL abort_post: got %h lat=%0d want 07e lat=8", res, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_wide;
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [33:0] e;
        int          lat;
        for (int i = 0; i < 7; i++) begin
            if (i == 0) begin
                a = 16'hFFFF; b = 16'h0001; ci = 1'b1;
            end else begin
                a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
            end
            e = add_model(16, 32'(a), 32'(b), ci);
            bus16.start = 1'b1;
            bus16.a     = a;
            bus16.b     = b;
            bus16.cin   = ci;
            @(posedge clk);
            #1;
            bus16.start = 1'b0;
            bus16.a     = 16'($urandom);
            bus16.b     = 16'($urandom);
            lat = 0;
            while (bus16.done !== 1'b1 && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            total++;
            if ({bus16.overflow, bus16.cout, bus16.sum} !== {e[33:32], e[15:0]} || lat != 4) begin
                bad++;
                $display("FAIL wide16[%0d] %h+%h+%b: got %h lat=%0d want %h lat=4", i, a, b, ci,
                         {bus16.overflow, bus16.cout, bus16.sum}, lat, {e[33:32], e[15:0]});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_full_digit;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ci;
        logic [33:0] e;
        int          lat;
        int          bc;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                a = 8'h7F; b = 8'h01; ci = 1'b0;
            end else begin
                a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
            end
            e = add_model(8, 32'(a), 32'(b), ci);
            bus8w.start = 1'b1;
            bus8w.a     = a;
            bus8w.b     = b;
            bus8w.cin   = ci;
            @(posedge clk);
            #1;
            bus8w.start = 1'b0;
            lat = 0;
            bc  = 0;
            while (bus8w.done !== 1'b1 && lat < 20) begin
                if (bus8w.busy === 1'b1) bc++;
                @(posedge clk);
                #1;
                lat++;
            end
            total++;
            if ({bus8w.overflow, bus8w.cout, bus8w.sum} !== {e[33:32], e[7:0]} || lat != 1 || bc != 1) begin
                bad++;
                $display("FAIL full_digit[%0d]: got %h lat=%0d busy_cycles=%0d want %h lat=1 busy_cycles=1", i,
                         {bus8w.overflow, bus8w.cout, bus8w.sum}, lat, bc, {e[33:32], e[7:0]});
            end
            @(posedge clk);
            #1;
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ci;
        logic [33:0] e;
        logic [9:0]  res;
        int          lat;
        int          bc;
        sub8 = 1'b1;
        run8(8'h05, 8'h07, 1'b0, res, lat, bc);
        total++;
        if (res !== 10'h0FE) begin
            bad++;
            $display("FAIL sub_05_07: got %h want 0fe", res);
        end
        run8(8'h80, 8'h01, 1'b0, res, lat, bc);
        total++;
        if (res !== 10'h37F) begin
            bad++;
            $display("FAIL sub_80_01: got %h want 37f", res);
        end
        for (int i = 0; i < 12; i++) begin
            a    = 8'($urandom);
            b    = 8'($urandom);
            ci   = 1'($urandom);
            sub8 = 1'($urandom);
            e    = sub8 ? sub_model(8, 32'(a), 32'(b)) : add_model(8, 32'(a), 32'(b), ci);
            run8(a, b, ci, res, lat, bc);
            total++;
            if (res !== {e[33:32], e[7:0]}) begin
                bad++;
                $display("FAIL sub_random[%0d] sub=%b %h,%h,%b: got %h want %h", i, sub8, a, b, ci, res, {e[33:32], e[7:0]});
            end
        end
        sub8 = 1'b0;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        rst         = 1'b1;
        bus8.start  = 1'b0;  bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0;
        bus16.start = 1'b0;  bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
        bus8w.start = 1'b0;  bus8w.a = '0; bus8w.b = '0; bus8w.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        bus8.sub    = 1'b0;
        bus16.sub   = 1'b0;
        bus8w.sub   = 1'b0;
`endif
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_abort;
        test_wide;
        test_full_digit;
`ifdef SERIAL_ADDER_SUB_EN
        test_sub;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised multi-cycle adder built around the full-adder slice: captures two WIDTH-bit operands plus carry-in on a start strobe and ripples DIGIT bits per clock through a registered carry. Reports sum, carry-out and signed overflow with a one-cycle done pulse. Sits in the arithmetic library as the area-lean successor to the single-bit full adder, for datapaths that trade latency for gate count.

## Interface
- WIDTH, 8, operand and sum width in bits; ≥ 1.
- DIGIT, 1, bits added per clock; must divide WIDTH evenly. Derived N = WIDTH/DIGIT = processing cycles.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled each rising edge; accepted only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- sub  input  1  subtract select, captured on accepted start; present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, result valid.
- sum  output  WIDTH  result register; holds last result until next completion.
- cout  output  1  carry out of MSB of last result.
- overflow  output  1  signed overflow of last result = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → capture a, b, cin (and sub), clear digit counter, working carry = cin → RUN.
- RUN: each edge adds digit[cnt] of A and B with working carry via DIGIT chained full-adder slices, LSB digit first; stores partial sum digit and carry; cnt++. After digit N−1 processed → DONE; sum/cout/overflow registered on that same edge.
- DONE: done=1 for exactly one cycle. start=1 on the edge leaving DONE → accepted as in IDLE (back-to-back, goes directly to RUN); else → IDLE.
- start while in RUN: ignored, no effect on operands or progress; no queuing.
- Arithmetic: modulo 2^WIDTH; cout is bit WIDTH of a+b+cin. Overflow needs the carry into bit WIDTH−1, tracked inside the final digit.
- Inputs a, b, cin may change freely after capture.

## Timing
- Reset (rst=1 at an edge): state IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, counter=0. Dominates start and any in-progress operation; an aborted operation produces no done and no result update.
- Start accepted at edge t → busy=1 during cycles after edges t..t+N−1; result registered and done=1 in cycle after edge t+N; busy=0 in that cycle.
- Latency start-edge→done = N+1 edges... specifically done asserted N edges after the accepting edge; throughput one result per N+1 cycles with back-to-back starts.
- WIDTH=8, DIGIT=1: done 8 edges after start; DIGIT=4: 2 edges; DIGIT=WIDTH: 1 edge.
- busy and done never high simultaneously.

## Configuration
- SERIAL_ADDER_SUB_EN defined: sub port exists; sub=1 at capture computes a − b as a + ~b + 1 (cin ignored, forced to 1); cout=1 means no borrow; overflow is signed-subtraction overflow.
- Not defined: no sub port; add only, a + b + cin.

## Test plan
- WIDTH=8, DIGIT=1: reset, then start with a=0x00, b=0x00, cin=0 → busy 8 cycles, done pulse once, sum=0x00, cout=0, overflow=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0; a=0x7F, b=0x01, cin=0 → sum=0x80, cout=0, overflow=1; a=0x80, b=0x80, cin=1 → sum=0x01, cout=1, overflow=1.
- start held high continuously with new operands during RUN → operands changed mid-RUN ignored; result matches values captured at accepting edge; next start accepted from DONE, done pulses every 9 cycles.
- rst asserted at 4th RUN cycle of a=0x3C+b=0x42 → next cycle busy=0, done never pulses, sum/cout/overflow=0; subsequent start completes normally (0x3C+0x42 → 0x7E).
- WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, cin=1 → done 4 edges after start, sum=0x0001, cout=1, overflow=0.
- With SERIAL_ADDER_SUB_EN, WIDTH=8: sub=1, a=0x05, b=0x07 → sum=0xFE, cout=0; a=0x80, b=0x01 → sum=0x7F, cout=1, overflow=1.
